// File: rtl/push_arbiter.sv
// push_arbiter: first-press-wins arbiter ("quiz buzzer") for N asynchronous pushbuttons.
// Latency: push/tie are registered, 3 cycles after the first edge that samples a press (+DB_CYCLES with debounce).
// Backpressure: none; a round stays locked until clr, and new rounds wait until every button is released.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   pb      raw active-high pushbuttons, asynchronous to clk, bit i = channel i
//   clr     synchronous round clear (acts only while locked)
//   push    one-cycle pulse when a single winner is latched
//   tie     one-cycle pulse when two or more channels press in the same cycle
//   winner  index of the latched winner, held until the next win or reset
//   locked  high while a winner is held
//
// Build option: define PUSH_ARB_DEBOUNCE_EN to add a DB_CYCLES-long stability
// filter per channel; without it the filtered level is the synchronised level.
module push_arbiter #(
   parameter int N         = 2,
   parameter int IW        = 1,
   parameter int DB_CYCLES = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  pb,
   input  logic          clr,
   output logic          push,
   output logic          tie,
   output logic [IW-1:0] winner,
   output logic          locked
);

   // Elaboration-time parameter sanity.
   if (N < 2 || N > 16) begin : g_bad_n
      $error("push_arbiter: N must be in 2..16");
   end
   if (IW != ((N > 2) ? $clog2(N) : 1)) begin : g_bad_iw
      $error("push_arbiter: IW must equal max(1, clog2(N))");
   end
   if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db
      $error("push_arbiter: DB_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOCKED  = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   logic [N-1:0] sync1;
   logic [N-1:0] sync2;
   logic [N-1:0] filt;
   logic [N-1:0] filt_prev;
   logic [N-1:0] armed;
   logic [N-1:0] press;
   logic         any_press;
   logic         multi_press;
   logic [IW-1:0] press_idx;
   state_t       state;

   // Two-flop synchroniser on every channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pb;
         sync2 <= sync1;
      end
   end

`ifdef PUSH_ARB_DEBOUNCE_EN
   // Cycles after reset before filt truly reflects the buttons.
   localparam int         SETTLE  = 2 + DB_CYCLES;
   localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

   logic [7:0]   db_cnt [N];
   logic [N-1:0] filt_q;

   // Counter runs while the synchronised level disagrees with the filtered
   // level; any agreement restarts it, so glitches shorter than DB_CYCLES die.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= '0;
         for (int i = 0; i < N; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (sync2[i] == filt_q[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               filt_q[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 8'd1;
            end
         end
      end
   end

   assign filt = filt_q;
`else
   localparam int SETTLE = 2;

   assign filt = sync2;
`endif

   localparam logic [8:0] SETTLE_LAST = 9'(SETTLE);

   logic [8:0] settle_cnt;
   logic       settled;

   assign settled = (settle_cnt == SETTLE_LAST);

   // The synchronisers reset to 0, so a button held through reset would look
   // like a fresh rising edge. A channel is only armed once its filtered level
   // has been seen low after the pipeline has refilled with real samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settle_cnt <= '0;
         filt_prev  <= '0;
         armed      <= '0;
      end else begin
         if (!settled) settle_cnt <= settle_cnt + 9'd1;
         filt_prev <= filt;
         if (settled) armed <= armed | ~filt;
      end
   end

   assign press = filt & ~filt_prev & armed;

   always_comb begin
      any_press   = 1'b0;
      multi_press = 1'b0;
      press_idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (press[i]) begin
            if (any_press) multi_press = 1'b1;
            any_press = 1'b1;
            press_idx = IW'(i);
         end
      end
   end

   // Round FSM with registered outputs; locked tracks the LOCKED state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         push   <= 1'b0;
         tie    <= 1'b0;
         winner <= '0;
         locked <= 1'b0;
      end else begin
         push <= 1'b0;
         tie  <= 1'b0;
         case (state)
            S_IDLE: begin
               // clr is deliberately not looked at here
               if (multi_press) begin
                  state <= S_RELEASE;
                  tie   <= 1'b1;
               end else if (any_press) begin
                  state  <= S_LOCKED;
                  winner <= press_idx;
                  push   <= 1'b1;
                  locked <= 1'b1;
               end
            end
            S_LOCKED: begin
               if (clr) begin
                  state  <= S_RELEASE;
                  locked <= 1'b0;
               end
            end
            S_RELEASE: begin
               if (filt == '0) state <= S_IDLE;
            end
            default: begin
               state  <= S_IDLE;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_push_arbiter.sv
// tb_push_arbiter: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the arbiter (N = 4).
module tb_push_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;
`ifdef PUSH_ARB_DEBOUNCE_EN
   localparam int DB = 4;
`else
   localparam int DB = 0;
`endif
   localparam int LAT = 3 + DB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  pb  = '0;
   logic          clr = 1'b0;
   logic          push;
   logic          tie;
   logic [IW-1:0] winner;
   logic          locked;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   push_arbiter #(.N(N), .IW(IW), .DB_CYCLES(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .pb     (pb),
      .clr    (clr),
      .push   (push),
      .tie    (tie),
      .winner (winner),
      .locked (locked)
   );

   // ---------------- behavioural reference model ----------------
   // hist[j] = pb sampled j edges ago. Filtered level: the sample from the
   // previous edge, or with debouncing the level flips once the synchronised
   // samples of the last DB cycles all disagree with it. A channel may only
   // win after it was seen released since reset.
   logic [N-1:0]  hist [0:7];
   logic [N-1:0]  m_filt, m_prev, m_seen_low;
   logic          m_locked, m_wait_rel, m_push, m_tie;
   logic [IW-1:0] m_winner;

   initial begin : model
      logic [N-1:0] pr;
      bit           all_diff;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            for (int j = 0; j < 8; j++) hist[j] = '0;
            m_filt = '0; m_prev = '0; m_seen_low = '0;
            m_locked = 1'b0; m_wait_rel = 1'b0; m_push = 1'b0; m_tie = 1'b0;
            m_winner = '0;
         end else begin
            pr = m_filt & ~m_prev & m_seen_low;
            m_push = 1'b0;
            m_tie  = 1'b0;
            if (m_locked) begin
               if (clr) begin m_locked = 1'b0; m_wait_rel = 1'b1; end
            end else if (m_wait_rel) begin
               if (m_filt == '0) m_wait_rel = 1'b0;
            end else if ($countones(pr) == 1) begin
               m_locked = 1'b1;
               m_push   = 1'b1;
               for (int i = 0; i < N; i++) if (pr[i]) m_winner = IW'(i);
            end else if ($countones(pr) > 1) begin
               m_wait_rel = 1'b1;
               m_tie      = 1'b1;
            end
            for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = pb;
            m_seen_low = m_seen_low | ~pb;
            m_prev = m_filt;
            if (DB == 0) begin
               m_filt = hist[1];
            end else begin
               for (int i = 0; i < N; i++) begin
                  all_diff = 1'b1;
                  for (int j = 2; j <= DB + 1; j++)
                     if (hist[j][i] == m_filt[i]) all_diff = 1'b0;
                  if (all_diff) m_filt[i] = ~m_filt[i];
               end
            end
         end
      end
   end

   // ---------------- stimulus / observation helpers ----------------
   task automatic do_reset();
      pb = '0; clr = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (DB + 6) @(negedge clk);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Observe `cycles` negedges; cycle k is the k-th edge after the call.
   task automatic watch(input int cycles, output int first_push, output int first_tie,
                        output int n_push, output int n_tie);
      first_push = -1; first_tie = -1; n_push = 0; n_tie = 0;
      for (int k = 1; k <= cycles; k++) begin
         @(negedge clk);
         if (push === 1'b1) begin n_push++; if (first_push < 0) first_push = k; end
         if (tie === 1'b1) begin n_tie++; if (first_tie < 0) first_tie = k; end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int fp, ft, np, nt;
      pb = '0; clr = 1'b0; rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({push, tie, locked} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {push, tie, locked});
      else n_pass++;
      n_chk++;
      if (winner !== 2'd0) $display("FAIL reset_winner: got %0d expected 0", winner);
      else n_pass++;
      rst = 1'b0;
      watch(DB + 8, fp, ft, np, nt);
      n_chk++;
      if (np + nt !== 0 || locked !== 1'b0)
         $display("FAIL reset_idle_quiet: pushes %0d ties %0d locked %b expected 0 0 0", np, nt, locked);
      else n_pass++;
   endtask

   task automatic test_single_press();
      int fp, ft, np, nt;
      do_reset();
      pb = 4'b0001;
      watch(LAT + 6, fp, ft, np, nt);
      n_chk++;
      if (fp !== LAT || np !== 1 || nt !== 0)
         $display("FAIL single_push: first %0d count %0d ties %0d expected %0d 1 0", fp, np, nt, LAT);
      else n_pass++;
      n_chk++;
      if (winner !== 2'd0 || locked !== 1'b1)
         $display("FAIL single_lock: winner %0d locked %b expected 0 1", winner, locked);
      else n_pass++;
      pulse_clr();
      n_chk++;
      if (locked !== 1'b0) $display("FAIL clr_unlock: locked %b expected 0", locked);
      else n_pass++;
      pb = '0;
      repeat (DB + 4) @(negedge clk);
      pb = 4'b0010;
      watch(LAT + 2, fp, ft, np, nt);
      n_chk++;
      if (fp !== LAT || np !== 1 || winner !== 2'd1)
         $display("FAIL repress_after_clr: first %0d count %0d winner %0d expected %0d 1 1", fp, np, winner, LAT);
      else n_pass++;
      pulse_clr();
      pb = '0;
      repeat (DB + 4) @(negedge clk);
   endtask

   task automatic test_tie();
      int fp, ft, np, nt;
      do_reset();
      pb = 4'b1000;
      watch(LAT + 1, fp, ft, np, nt);
      n_chk++;
      if (winner !== 2'd3) $display("FAIL tie_setup_winner: got %0d expected 3", winner);
      else n_pass++;
      pulse_clr();
      pb = '0;
      repeat (DB + 4) @(negedge clk);
      pb = 4'b0110;
      watch(LAT + 4, fp, ft, np, nt);
      n_chk++;
      if (ft !== LAT || nt !== 1 || np !== 0)
         $display("FAIL tie_pulse: first %0d ties %0d pushes %0d expected %0d 1 0", ft, nt, np, LAT);
      else n_pass++;
      n_chk++;
      if (winner !== 2'd3 || locked !== 1'b0)
         $display("FAIL tie_hold: winner %0d locked %b expected 3 0", winner, locked);
      else n_pass++;
      pb = '0;
      repeat (DB + 4) @(negedge clk);
      pb = 4'b0001;
      watch(LAT + 2, fp, ft, np, nt);
      n_chk++;
      if (fp !== LAT || np !== 1 || winner !== 2'd0)
         $display("FAIL tie_repress: first %0d count %0d winner %0d expected %0d 1 0", fp, np, winner, LAT);
      else n_pass++;
   endtask

   task automatic test_late_press();
      int fp, ft, np, nt;
      do_reset();
      pb = 4'b0100;
      repeat (2) @(negedge clk);
      pb = 4'b1100;
      watch(LAT + 8, fp, ft, np, nt);
      n_chk++;
      if (fp !== LAT - 2 || np !== 1 || nt !== 0)
         $display("FAIL late_press_events: first %0d pushes %0d ties %0d expected %0d 1 0", fp, np, nt, LAT - 2);
      else n_pass++;
      n_chk++;
      if (winner !== 2'd2 || locked !== 1'b1)
         $display("FAIL late_press_winner: winner %0d locked %b expected 2 1", winner, locked);
      else n_pass++;
      pulse_clr();
      pb = '0;
      repeat (DB + 4) @(negedge clk);
   endtask

   task automatic test_debounce();
      int fp, ft, np, nt;
      int short_len, long_len, exp_short;
      short_len = (DB > 0) ? DB - 1 : 1;
      long_len  = DB + 2;
      exp_short = (DB == 0) ? 1 : 0;
      do_reset();
      pb = 4'b0001;
      repeat (short_len) @(negedge clk);
      pb = '0;
      watch(LAT + 6, fp, ft, np, nt);
      n_chk++;
      if (np !== exp_short) $display("FAIL short_pulse: pushes %0d expected %0d", np, exp_short);
      else n_pass++;
      // from IDLE this clr must be harmless; from LOCKED it opens the next round
      pulse_clr();
      repeat (DB + 4) @(negedge clk);
      pb = 4'b0001;
      watch(long_len, fp, ft, np, nt);
      n_chk++;
      if (np !== 0) $display("FAIL long_pulse_early: pushes %0d expected 0", np);
      else n_pass++;
      pb = '0;
      watch(6, fp, ft, np, nt);
      n_chk++;
      if (fp !== LAT - long_len || np !== 1)
         $display("FAIL long_pulse_push: first %0d count %0d expected %0d 1", fp, np, LAT - long_len);
      else n_pass++;
      pulse_clr();
      repeat (DB + 4) @(negedge clk);
   endtask

   task automatic test_reset_midround();
      int fp, ft, np, nt;
      do_reset();
      pb = 4'b0010;
      watch(LAT + 1, fp, ft, np, nt);
      n_chk++;
      if (locked !== 1'b1 || winner !== 2'd1)
         $display("FAIL midrst_setup: locked %b winner %0d expected 1 1", locked, winner);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({push, tie, locked} !== 3'b000 || winner !== 2'd0)
         $display("FAIL midrst_immediate: flags %b winner %0d expected 000 0", {push, tie, locked}, winner);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      watch(DB + 12, fp, ft, np, nt);
      n_chk++;
      if (np !== 0 || nt !== 0 || locked !== 1'b0)
         $display("FAIL midrst_held: pushes %0d ties %0d locked %b expected 0 0 0", np, nt, locked);
      else n_pass++;
      pb = '0;
      repeat (DB + 4) @(negedge clk);
      pb = 4'b0010;
      watch(LAT + 2, fp, ft, np, nt);
      n_chk++;
      if (fp !== LAT || np !== 1 || winner !== 2'd1)
         $display("FAIL midrst_repress: first %0d count %0d winner %0d expected %0d 1 1", fp, np, winner, LAT);
      else n_pass++;
      pulse_clr();
      pb = '0;
      repeat (DB + 4) @(negedge clk);
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         n_chk++;
         if (push !== m_push) $display("FAIL rand_push: cycle %0d got %b expected %b", c, push, m_push);
         else n_pass++;
         n_chk++;
         if (tie !== m_tie) $display("FAIL rand_tie: cycle %0d got %b expected %b", c, tie, m_tie);
         else n_pass++;
         n_chk++;
         if (locked !== m_locked) $display("FAIL rand_locked: cycle %0d got %b expected %b", c, locked, m_locked);
         else n_pass++;
         n_chk++;
         if (winner !== m_winner) $display("FAIL rand_winner: cycle %0d got %0d expected %0d", c, winner, m_winner);
         else n_pass++;
         n_chk++;
         if ((push & tie) !== 1'b0) $display("FAIL rand_exclusive: cycle %0d push %b tie %b expected not both", c, push, tie);
         else n_pass++;
         r = $urandom_range(0, 15);
         clr = 1'b0;
         if (r == 0)      pb = N'($urandom);
         else if (r == 1) pb = '0;
         else if (r == 2) pb[$urandom_range(0, N - 1)] = ~pb[$urandom_range(0, N - 1)];
         else if (r == 3) clr = 1'b1;
      end
      clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_tie();
      test_late_press();
      test_debounce();
      test_reset_midround();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/push_arbiter.md
PUSH_ARBITER -- requirements
Module: push_arbiter

Interface
REQ-001 Parameter N, default 2: number of pushbutton channels, legal range 2..16.
REQ-002 Parameter IW, default 1: winner index width; SHALL equal max(1, ceil(log2(N))).
REQ-003 Parameter DB_CYCLES, default 4: debounce stability length in clk cycles, legal range 1..255.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pb  input  N  raw pushbuttons, active-high, asynchronous to clk; bit i is channel i.
REQ-007 clr  input  1  synchronous round clear, active-high.
REQ-008 push  output  1  one-cycle pulse when a single winner is latched.
REQ-009 tie  output  1  one-cycle pulse when two or more channels press in the same cycle.
REQ-010 winner  output  IW  index of the latched winner; holds until next win or reset.
REQ-011 locked  output  1  high while the arbiter holds a winner (state LOCKED).

Function
REQ-012 Each pb bit SHALL pass through a 2-flop synchroniser before any use.
REQ-013 Press detection SHALL be rising-edge on the filtered channel (filtered 1 AND previous filtered 0); a level held high never re-triggers.
REQ-014 FSM states: IDLE, LOCKED, RELEASE; encoding free; unreachable encodings SHALL return to IDLE.
REQ-015 IDLE, exactly one press this cycle -> LOCKED; winner<=its index; push pulses 1 cycle.
REQ-016 IDLE, two or more presses in the same cycle -> RELEASE; tie pulses 1 cycle; winner unchanged; push stays 0.
REQ-017 IDLE, no press -> IDLE; clr in IDLE has no effect.
REQ-018 LOCKED: presses ignored, no push/tie; clr=1 -> RELEASE.
REQ-019 RELEASE: once all filtered channels are 0 -> IDLE; presses while any channel is high SHALL be ignored.
REQ-020 clr and a press in the same IDLE cycle: the press is processed; clr is ignored.
REQ-021 Outputs SHALL be registered; latency without debounce: push/tie high in the 3rd clk cycle after the first rising edge that samples pb high.
REQ-022 push and tie SHALL never be high together; each is high for exactly one cycle per event.
REQ-023 locked SHALL be high iff the state is LOCKED.

Reset
REQ-024 rst=1 SHALL immediately force: state IDLE, push=0, tie=0, locked=0, winner=0, synchronisers=0, previous-filtered=0, debounce counters=0.
REQ-025 rst mid-round (LOCKED or RELEASE) SHALL discard the round; after rst releases, a button still held produces no press until it is released and re-pressed.

Configuration
REQ-026 Macro PUSH_ARB_DEBOUNCE_EN defined: each channel has a counter; the filtered level changes only after the synchronised level has differed from it for DB_CYCLES consecutive cycles; shorter glitches are rejected; latency grows by DB_CYCLES cycles.
REQ-027 PUSH_ARB_DEBOUNCE_EN undefined: filtered level equals the synchronised level; no counters are instantiated; DB_CYCLES is ignored.

Verification
REQ-028 N=2, no debounce, pb=01 held from cycle 0 -> push=1 in cycle 3 only, winner=0, locked=1; clr=1 for 1 cycle then pb=00 -> locked=0, state IDLE.
REQ-029 N=4, pb=0110 rising in the same cycle -> tie=1 for 1 cycle, push=0, winner unchanged, locked=0; re-press after releasing all -> accepted.
REQ-030 N=4, pb[2] pressed, then pb[3] pressed 2 cycles later -> winner=2, single push; pb[3] never produces push or tie.
REQ-031 PUSH_ARB_DEBOUNCE_EN, DB_CYCLES=4: a 3-cycle pb pulse -> no push; a 6-cycle pulse -> push exactly 7 cycles after its first sampled edge.
REQ-032 rst asserted while LOCKED with pb[1] held -> outputs 0 immediately; after rst deasserts, no push until pb[1] is released and pressed again, then winner=1.
